// File: rtl/collision_engine.sv
// collision_engine: time-multiplexed map/pair collision checker for N_ENT entities.
// Ports: clock, reset, start/busy/done handshake, packed pos_x/pos_y/dir, map ROM (map_address/map_q),
//        map_collision, pair_collision; blocked_dir when COLLISION_FACING_EN is defined.
module collision_engine #(
  parameter int N_ENT    = 2,
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int STEP     = 1,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int ADDR_W   = 17
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N_ENT*X_W-1:0] pos_x,
  input  logic [N_ENT*Y_W-1:0] pos_y,
  input  logic [N_ENT*3-1:0]   dir,
  output logic [ADDR_W-1:0]    map_address,
  input  logic                 map_q,
  output logic                 busy,
  output logic                 done,
  output logic [N_ENT-1:0]     map_collision,
  output logic [N_ENT-2:0]     pair_collision
`ifdef COLLISION_FACING_EN
  ,
  output logic [N_ENT*3-1:0]   blocked_dir
`endif
);

  localparam int EW  = (N_ENT > 2) ? $clog2(N_ENT) : 1;
  localparam int XW1 = X_W + 1;
  localparam int YW1 = Y_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROBE,
    S_WAIT,
    S_PAIR,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [N_ENT*X_W-1:0] snap_x_q;
  logic [N_ENT*Y_W-1:0] snap_y_q;
  logic [N_ENT*3-1:0]   snap_d_q;
  logic [EW-1:0]        ent_q;
  logic [1:0]           corner_q;
  logic                 off_q;
  logic [N_ENT-1:0]     map_acc_q;
  logic [N_ENT-2:0]     pair_acc_q;

  // Returns {off_screen, rom_address} for one corner of a projected box.
  function automatic logic [ADDR_W:0] probe_slot(
    input logic [X_W-1:0] x,
    input logic [Y_W-1:0] y,
    input logic [2:0]     d,
    input logic [1:0]     c
  );
    logic signed [X_W:0] cx;
    logic signed [Y_W:0] cy;
    logic                off;
    cx = $signed({1'b0, x});
    cy = $signed({1'b0, y});
    case (d)
      3'd2:    cy = cy - YW1'(STEP);
      3'd3:    cy = cy + YW1'(STEP);
      3'd4:    cx = cx - XW1'(STEP);
      3'd5:    cx = cx + XW1'(STEP);
      default: ;
    endcase
    if (c[0]) cx = cx + XW1'(SPRITE_W - 1);
    if (c[1]) cy = cy + YW1'(SPRITE_H - 1);
    off = cx[X_W] || (cx >= $signed(XW1'(SCREEN_W)))
       || cy[Y_W] || (cy >= $signed(YW1'(SCREEN_H)));
    return {off, ADDR_W'(cy[Y_W-1:0]) * ADDR_W'(SCREEN_W)
               + ADDR_W'(cx[X_W-1:0])};
  endfunction

  logic [EW-1:0]     nent;
  logic [1:0]        ncor;
  logic [ADDR_W:0]   slot_first;
  logic [ADDR_W:0]   slot_next;
  logic              last_slot;
  logic              last_pair;
  logic              blocked;
  logic signed [X_W:0] dx;
  logic signed [Y_W:0] dy;
  logic [X_W:0]      adx;
  logic [Y_W:0]      ady;
  logic              hit;
  logic [N_ENT-2:0]  pair_nxt;

  always_comb begin
    ncor = corner_q + 2'd1;
    nent = (corner_q == 2'd3) ? ent_q + EW'(1) : ent_q;
    slot_first = probe_slot(pos_x[X_W-1:0], pos_y[Y_W-1:0],
                            dir[2:0], 2'd0);
    slot_next  = probe_slot(snap_x_q[nent*X_W +: X_W],
                            snap_y_q[nent*Y_W +: Y_W],
                            snap_d_q[nent*3 +: 3], ncor);
    last_slot = (ent_q == EW'(N_ENT - 1)) && (corner_q == 2'd3);
    last_pair = (ent_q == EW'(N_ENT - 1));
    blocked   = off_q | ~map_q;
    // Pair test uses the unprojected snapshot positions.
    dx  = $signed({1'b0, snap_x_q[X_W-1:0]})
        - $signed({1'b0, snap_x_q[ent_q*X_W +: X_W]});
    dy  = $signed({1'b0, snap_y_q[Y_W-1:0]})
        - $signed({1'b0, snap_y_q[ent_q*Y_W +: Y_W]});
    adx = dx[X_W] ? -dx : dx;
    ady = dy[Y_W] ? -dy : dy;
    hit = (adx < XW1'(SPRITE_W)) && (ady < YW1'(SPRITE_H));
    pair_nxt = pair_acc_q;
    for (int j = 1; j < N_ENT; j++)
      if (ent_q == EW'(j)) pair_nxt[j-1] = hit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      snap_x_q       <= '0;
      snap_y_q       <= '0;
      snap_d_q       <= '0;
      ent_q          <= '0;
      corner_q       <= '0;
      off_q          <= 1'b0;
      map_acc_q      <= '0;
      pair_acc_q     <= '0;
      map_address    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      map_collision  <= '0;
      pair_collision <= '0;
`ifdef COLLISION_FACING_EN
      blocked_dir    <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            snap_x_q    <= pos_x;
            snap_y_q    <= pos_y;
            snap_d_q    <= dir;
            ent_q       <= '0;
            corner_q    <= '0;
            map_acc_q   <= '0;
            pair_acc_q  <= '0;
            map_address <= slot_first[ADDR_W-1:0];
            off_q       <= slot_first[ADDR_W];
            busy        <= 1'b1;
            state_q     <= S_PROBE;
          end
        end
        S_PROBE: state_q <= S_WAIT;
        S_WAIT: begin
          for (int i = 0; i < N_ENT; i++)
            if (ent_q == EW'(i))
              map_acc_q[i] <= map_acc_q[i] | blocked;
          if (last_slot) begin
            ent_q   <= EW'(1);
            state_q <= S_PAIR;
          end else begin
            ent_q       <= nent;
            corner_q    <= ncor;
            map_address <= slot_next[ADDR_W-1:0];
            off_q       <= slot_next[ADDR_W];
            state_q     <= S_PROBE;
          end
        end
        S_PAIR: begin
          pair_acc_q <= pair_nxt;
          if (last_pair) begin
            map_collision  <= map_acc_q;
            pair_collision <= pair_nxt;
`ifdef COLLISION_FACING_EN
            for (int i = 0; i < N_ENT; i++)
              blocked_dir[i*3 +: 3] <= map_acc_q[i]
                                     ? snap_d_q[i*3 +: 3] : 3'd0;
`endif
            done    <= 1'b1;
            state_q <= S_DONE;
          end else begin
            ent_q <= ent_q + EW'(1);
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_engine.sv
// tb_collision_engine: randomized self-checking bench for collision_engine (N_ENT=2)
// with a behavioural map/overlap model and a pixel-array ROM model.
module tb_collision_engine;

  localparam int N    = 2;
  localparam int XW   = 9;
  localparam int YW   = 8;
  localparam int AW   = 17;
  localparam int SW   = 320;
  localparam int SH   = 240;
  localparam int SPW  = 16;
  localparam int SPH  = 16;
  localparam int NPIX = SW * SH;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [N*XW-1:0] pos_x = '0;
  logic [N*YW-1:0] pos_y = '0;
  logic [N*3-1:0]  dir = '0;
  logic [AW-1:0]   map_address;
  logic            map_q = 1'b1;
  logic            busy;
  logic            done;
  logic [N-1:0]    map_collision;
  logic [N-2:0]    pair_collision;

  int n_tests = 0;
  int n_fail  = 0;

  logic rom [0:NPIX-1];

  collision_engine dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .pos_x          (pos_x),
    .pos_y          (pos_y),
    .dir            (dir),
    .map_address    (map_address),
    .map_q          (map_q),
    .busy           (busy),
    .done           (done),
    .map_collision  (map_collision),
    .pair_collision (pair_collision)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    map_q <= (int'(map_address) < NPIX) ? rom[map_address] : 1'b1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: all walkable, 1: column col blocked, 2: random 1/8 blocked
  task automatic fill_rom(input int mode, input int col);
    for (int i = 0; i < NPIX; i++) begin
      if (mode == 0)      rom[i] = 1'b1;
      else if (mode == 1) rom[i] = ((i % SW) != col);
      else                rom[i] = ($urandom_range(0, 7) != 0);
    end
  endtask

  function automatic void proj(input int x, input int y, input int d,
                               output int px, output int py);
    px = x;
    py = y;
    if (d == 2) py = y - 1;
    if (d == 3) py = y + 1;
    if (d == 4) px = x - 1;
    if (d == 5) px = x + 1;
  endfunction

  function automatic bit mdl_blocked(input int x, input int y, input int d);
    int px, py, cx, cy;
    proj(x, y, d, px, py);
    for (int c = 0; c < 4; c++) begin
      cx = px + ((c % 2) ? SPW - 1 : 0);
      cy = py + ((c / 2) ? SPH - 1 : 0);
      if (cx < 0 || cx >= SW || cy < 0 || cy >= SH) return 1'b1;
      if (!rom[cy * SW + cx]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One full pass; optional extra start pulse at cycle dup_at (0 = none).
  task automatic run_pass(input int x0, input int y0, input int d0,
                          input int x1, input int y1, input int d1,
                          input int dup_at);
    int lat, px, py;
    bit exp_m0, exp_m1, exp_p;
    exp_m0 = mdl_blocked(x0, y0, d0);
    exp_m1 = mdl_blocked(x1, y1, d1);
    exp_p  = (iabs(x0 - x1) < SPW) && (iabs(y0 - y1) < SPH);
    proj(x0, y0, d0, px, py);
    pos_x = {XW'(x1), XW'(x0)};
    pos_y = {YW'(y1), YW'(y0)};
    dir   = {3'(d1), 3'(d0)};
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    chk("busy_rise", busy, 1);
    if (px >= 0 && px < SW && py >= 0 && py < SH)
      chk("first_addr", map_address, py * SW + px);
    while (!done && lat < 60) begin
      tick();
      lat++;
      start = (lat == dup_at);
    end
    start = 1'b0;
    chk("done_latency", lat, 9 * N);
    chk("busy_at_done", busy, 1);
    chk("map_coll", map_collision, {exp_m1, exp_m0});
    chk("pair_coll", pair_collision, exp_p);
    tick();
    chk("done_pulse", done, 0);
    chk("busy_fall", busy, 0);
    chk("map_hold", map_collision, {exp_m1, exp_m0});
  endtask

  task automatic no_done_for(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    int x0, y0, x1, y1;
    fill_rom(0, 0);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_map", map_collision, 0);
    chk("rst_pair", pair_collision, 0);
    chk("rst_addr", map_address, 0);
    tick();

    run_pass(100, 100, 5, 200, 50, 2, 0);
    run_pass(304, 100, 5, 50, 0, 2, 0);
    run_pass(100, 100, 0, 115, 85, 0, 0);
    run_pass(100, 100, 0, 116, 100, 0, 0);
    run_pass(100, 100, 0, 85, 115, 0, 0);
    run_pass(0, 0, 4, 304, 224, 3, 0);

    run_pass(304, 100, 5, 50, 0, 2, 0);
    pos_x = {9'd200, 9'd100};
    pos_y = {8'd50, 8'd100};
    dir   = {3'd2, 3'd5};
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_map", map_collision, 0);
    chk("abort_pair", pair_collision, 0);
    chk("abort_addr", map_address, 0);
    no_done_for("abort_no_done", 30);
    run_pass(100, 100, 5, 200, 50, 2, 0);

    fill_rom(1, 116);
    run_pass(100, 100, 5, 200, 50, 2, 0);
    run_pass(99, 100, 5, 200, 50, 2, 0);
    run_pass(100, 100, 5, 200, 50, 2, 4);
    no_done_for("dup_start_ignored", 25);

    fill_rom(2, 0);
    for (int k = 0; k < 40; k++) begin
      x0 = $urandom_range(0, 320);
      y0 = $urandom_range(0, 240);
      if ($urandom_range(0, 1) == 1) begin
        x1 = x0 + $urandom_range(0, 40) - 20;
        y1 = y0 + $urandom_range(0, 40) - 20;
        if (x1 < 0) x1 = 0;
        if (y1 < 0) y1 = 0;
      end else begin
        x1 = $urandom_range(0, 320);
        y1 = $urandom_range(0, 240);
      end
      run_pass(x0, y0, $urandom_range(0, 7),
               x1, y1, $urandom_range(0, 7), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
